dyt_decode_stage: RTL and testbench
===================================

Name: dyt_decode_stage

Overview:
ID stage of the in-order RV32I pipeline. Accepts fetched instructions over a valid/ready handshake. It drives the register file read selects and captures the operands with write-back bypass. It generates the immediate and decoded fields into the ID/EX pipeline register. It also inserts load-use bubbles and honours pipeline flush from the branch-resolution logic.

Parameters:
XLEN, 32, datapath width; matches register file word width
RA_W, 5, register index width (32 architectural registers, x0 hard-zero)

Ports:
clk  in  1  clock
n_rst  in  1  asynchronous active-low reset
if_valid  in  1  fetch presents an instruction
if_ready  out  1  decode accepts the instruction this cycle
if_instr  in  XLEN  instruction word
if_pc  in  XLEN  instruction address
rf_r_sel_0  out  RA_W  register file read select 0 (rs1)
rf_r_sel_1  out  RA_W  register file read select 1 (rs2)
rf_r_data_0  in  XLEN  register file read data 0
rf_r_data_1  in  XLEN  register file read data 1
wb_wen  in  1  write-back writes this cycle (same signal that drives register file write enable)
wb_sel  in  RA_W  write-back destination
wb_data  in  XLEN  write-back data
ex_load_valid  in  1  EX holds a load
ex_load_rd  in  RA_W  destination of that load
flush  in  1  kill ID contents and the instruction offered this cycle
id_valid  out  1  ID/EX register holds a valid instruction
id_ready  in  1  EX accepts this cycle
id_pc, id_rs1_val, id_rs2_val, id_imm  out  XLEN each  registered PC, operands, sign-extended immediate
id_rs1, id_rs2, id_rd  out  RA_W each  registered register indices
id_opcode  out  7  registered opcode
id_funct3  out  3  registered funct3
id_funct7b5  out  1  registered instr[30]
id_rd_wen  out  1  instruction writes rd (0 when rd==x0)
id_illegal  out  1  unsupported opcode

Behaviour:
- Reset: all id_* outputs 0.
- if_ready is combinational.
- rf_r_sel_0/1 are combinational: always if_instr[19:15] / [24:20], independent of if_valid.
- Operand select, per source, in priority order:
  - index==0 → 0.
  - wb_wen && wb_sel==index → wb_data (bypass, because the RF updates only at the edge).
  - Otherwise → rf_r_data.
- Source use:
  - rs1 is used by all opcodes except LUI, AUIPC and JAL.
  - rs2 is used by OP, STORE and BRANCH.
- Hazard: hz = ex_load_valid && ex_load_rd!=0 && ex_load_rd matches a used source of if_instr.
- Handshake: if_ready = !flush && !hz && (!id_valid || id_ready).
- Per-cycle update:
  - flush → id_valid<=0.
  - else if if_valid && if_ready → capture all fields, id_valid<=1.
  - else if id_ready → id_valid<=0 (bubble, including the load-use case).
  - else hold.
- Load-use stall is exactly one cycle per matching load; the instruction stays at the fetch port (fetch holds if_instr while !if_ready).
- Held-operand refresh: while holding (id_valid && !id_ready), if wb_wen && wb_sel!=0 && wb_sel==id_rs1, then id_rs1_val<=wb_data; same for rs2.
- Immediate and decode by opcode:
  - OP 0110011: R, imm 0.
  - OP-IMM 0010011, LOAD 0000011, JALR 1100111: I, {sext instr[31:20]}.
  - STORE 0100011: S.
  - BRANCH 1100011: B, bit0=0.
  - LUI 0110111, AUIPC 0010111: U, {instr[31:12],12'b0}.
  - JAL 1101111: J, bit0=0.
  - Any other opcode: id_illegal=1, id_rd_wen=0, imm 0.
- id_rd_wen=1 for OP, OP-IMM, LOAD, LUI, AUIPC, JAL and JALR, only when rd!=0.
- Simultaneous events: flush beats capture and hazard. Bypass and held-operand refresh are applied in the same cycle as capture or hold.
- Reset mid-operation: state is cleared asynchronously and no instruction survives.

Test Plan:
- ADDI x5,x0,-3 (0xFFD00293), id_ready=1 → next cycle: id_valid=1, id_imm=0xFFFFFFFD, id_rd=5, id_rd_wen=1, id_rs1_val=0.
- ADD x3,x1,x2 with rf data 0x10/0x20 while wb_wen=1, wb_sel=2, wb_data=0x99 → id_rs1_val=0x10, id_rs2_val=0x99.
- ex_load_valid=1, ex_load_rd=1; offer ADD x3,x1,x2 → if_ready=0 for one cycle, id_valid=0 bubble; next cycle captured normally.
- id_ready=0 holding ADD x3,x1,x2; wb writes x1=0xABCD → id_rs1_val=0xABCD; if_ready=0 until id_ready=1.
- flush=1 with id_valid=1 and if_valid=1 → if_ready=0, id_valid=0 next cycle; n_rst pulse mid-stream → all outputs 0.
- BEQ offset -8 (0xFE000CE3) → id_imm=0xFFFFFFF8, id_rd_wen=0. Opcode 0x7F → id_illegal=1.

Source files
------------

// File: rtl/dyt_decode_stage.sv
// rtl/dyt_decode_stage.sv - RV32I decode stage: operand fetch with write-back bypass,
// immediate generation, load-use stall and flush into the ID/EX register.
module dyt_decode_stage #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [XLEN-1:0] if_instr,
  input  logic [XLEN-1:0] if_pc,
  output logic [RA_W-1:0] rf_r_sel_0,
  output logic [RA_W-1:0] rf_r_sel_1,
  input  logic [XLEN-1:0] rf_r_data_0,
  input  logic [XLEN-1:0] rf_r_data_1,
  input  logic            wb_wen,
  input  logic [RA_W-1:0] wb_sel,
  input  logic [XLEN-1:0] wb_data,
  input  logic            ex_load_valid,
  input  logic [RA_W-1:0] ex_load_rd,
  input  logic            flush,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_rs1_val,
  output logic [XLEN-1:0] id_rs2_val,
  output logic [XLEN-1:0] id_imm,
  output logic [RA_W-1:0] id_rs1,
  output logic [RA_W-1:0] id_rs2,
  output logic [RA_W-1:0] id_rd,
  output logic [6:0]      id_opcode,
  output logic [2:0]      id_funct3,
  output logic            id_funct7b5,
  output logic            id_rd_wen,
  output logic            id_illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  logic [6:0]      opc;
  logic [RA_W-1:0] rs1;
  logic [RA_W-1:0] rs2;
  logic [RA_W-1:0] rd;
  logic [XLEN-1:0] imm;
  logic            rd_wen;
  logic            illegal;
  logic            use_rs1;
  logic            use_rs2;
  logic            hz;
  logic [XLEN-1:0] op0;
  logic [XLEN-1:0] op1;

  assign opc = if_instr[6:0];
  assign rd  = if_instr[7 +: RA_W];
  assign rs1 = if_instr[15 +: RA_W];
  assign rs2 = if_instr[20 +: RA_W];

  assign rf_r_sel_0 = rs1;
  assign rf_r_sel_1 = rs2;

  always_comb begin
    imm     = '0;
    rd_wen  = 1'b0;
    illegal = 1'b0;
    use_rs1 = 1'b1;
    use_rs2 = 1'b0;
    case (opc)
      OPC_OP: begin
        rd_wen  = 1'b1;
        use_rs2 = 1'b1;
      end
      OPC_IMM, OPC_LOAD, OPC_JALR: begin
        imm    = XLEN'($signed(if_instr[31:20]));
        rd_wen = 1'b1;
      end
      OPC_STORE: begin
        imm     = XLEN'($signed({if_instr[31:25], if_instr[11:7]}));
        use_rs2 = 1'b1;
      end
      OPC_BRANCH: begin
        imm     = XLEN'($signed({if_instr[31], if_instr[7], if_instr[30:25],
                                 if_instr[11:8], 1'b0}));
        use_rs2 = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: begin
        imm     = XLEN'($signed({if_instr[31:12], 12'b0}));
        rd_wen  = 1'b1;
        use_rs1 = 1'b0;
      end
      OPC_JAL: begin
        imm     = XLEN'($signed({if_instr[31], if_instr[19:12], if_instr[20],
                                 if_instr[30:21], 1'b0}));
        rd_wen  = 1'b1;
        use_rs1 = 1'b0;
      end
      default: illegal = 1'b1;
    endcase
    if (rd == '0) rd_wen = 1'b0;
  end

  assign hz = ex_load_valid && (ex_load_rd != '0) &&
              ((use_rs1 && ex_load_rd == rs1) || (use_rs2 && ex_load_rd == rs2));

  assign if_ready = !flush && !hz && (!id_valid || id_ready);

  // The register file only updates at the edge, so a same-cycle write must be forwarded.
  assign op0 = (rs1 == '0) ? '0 :
               (wb_wen && wb_sel == rs1) ? wb_data : rf_r_data_0;
  assign op1 = (rs2 == '0) ? '0 :
               (wb_wen && wb_sel == rs2) ? wb_data : rf_r_data_1;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      id_valid    <= 1'b0;
      id_pc       <= '0;
      id_rs1_val  <= '0;
      id_rs2_val  <= '0;
      id_imm      <= '0;
      id_rs1      <= '0;
      id_rs2      <= '0;
      id_rd       <= '0;
      id_opcode   <= '0;
      id_funct3   <= '0;
      id_funct7b5 <= 1'b0;
      id_rd_wen   <= 1'b0;
      id_illegal  <= 1'b0;
    end else if (flush) begin
      id_valid <= 1'b0;
    end else if (if_valid && if_ready) begin
      id_valid    <= 1'b1;
      id_pc       <= if_pc;
      id_rs1_val  <= op0;
      id_rs2_val  <= op1;
      id_imm      <= imm;
      id_rs1      <= rs1;
      id_rs2      <= rs2;
      id_rd       <= rd;
      id_opcode   <= opc;
      id_funct3   <= if_instr[14:12];
      id_funct7b5 <= if_instr[30];
      id_rd_wen   <= rd_wen;
      id_illegal  <= illegal;
    end else if (id_ready) begin
      id_valid <= 1'b0;
    end else if (id_valid) begin
      // A stalled instruction must still see results retiring underneath it.
      if (wb_wen && wb_sel != '0 && wb_sel == id_rs1) id_rs1_val <= wb_data;
      if (wb_wen && wb_sel != '0 && wb_sel == id_rs2) id_rs2_val <= wb_data;
    end
  end

endmodule

// File: tb/tb_dyt_decode_stage.sv
// tb/tb_dyt_decode_stage.sv - scoreboard bench for dyt_decode_stage: directed cases
// then randomized traffic against an architectural reference model.
module tb_dyt_decode_stage;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [4:0]  rf_r_sel_0;
  logic [4:0]  rf_r_sel_1;
  logic [31:0] rf_r_data_0;
  logic [31:0] rf_r_data_1;
  logic        wb_wen;
  logic [4:0]  wb_sel;
  logic [31:0] wb_data;
  logic        ex_load_valid;
  logic [4:0]  ex_load_rd;
  logic        flush;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_rs1_val;
  logic [31:0] id_rs2_val;
  logic [31:0] id_imm;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;
  logic [6:0]  id_opcode;
  logic [2:0]  id_funct3;
  logic        id_funct7b5;
  logic        id_rd_wen;
  logic        id_illegal;

  always #5 clk = ~clk;

  dyt_decode_stage #(.XLEN(32), .RA_W(5)) dut (
    .clk(clk), .n_rst(n_rst),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .rf_r_sel_0(rf_r_sel_0), .rf_r_sel_1(rf_r_sel_1),
    .rf_r_data_0(rf_r_data_0), .rf_r_data_1(rf_r_data_1),
    .wb_wen(wb_wen), .wb_sel(wb_sel), .wb_data(wb_data),
    .ex_load_valid(ex_load_valid), .ex_load_rd(ex_load_rd), .flush(flush),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_opcode(id_opcode), .id_funct3(id_funct3), .id_funct7b5(id_funct7b5),
    .id_rd_wen(id_rd_wen), .id_illegal(id_illegal)
  );

  // Architectural register file; x0 holds junk to prove the stage forces zero.
  logic [31:0] rf [32];
  assign rf_r_data_0 = rf[rf_r_sel_0];
  assign rf_r_data_1 = rf[rf_r_sel_1];

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        f7;
    logic [31:0] imm;
    logic        wen;
    logic        ill;
  } exp_t;

  exp_t sbq[$];
  int   vectors = 0;
  int   miscompares = 0;
  logic mvalid = 1'b0;
  logic acc_seen = 1'b0;
  logic [6:0] ops [10];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
    exp_t e;
    int v;
    logic [6:0] op;
    op = w[6:0];
    e.pc = pc; e.opc = op; e.rd = w[11:7]; e.rs1 = w[19:15]; e.rs2 = w[24:20];
    e.f3 = w[14:12]; e.f7 = w[30];
    e.ill = !(op inside {7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F});
    v = 0;
    if (op inside {7'h13, 7'h03, 7'h67}) v = $signed(w) >>> 20;
    else if (op == 7'h23) v = (($signed(w) >>> 25) * 32) + int'(w[11:7]);
    else if (op == 7'h63)
      v = -4096 * int'(w[31]) + 2048 * int'(w[7]) + 32 * int'(w[30:25]) + 2 * int'(w[11:8]);
    else if (op inside {7'h37, 7'h17}) v = int'(w & 32'hFFFFF000);
    else if (op == 7'h6F)
      v = -1048576 * int'(w[31]) + 4096 * int'(w[19:12]) + 2048 * int'(w[20]) + 2 * int'(w[30:21]);
    e.imm = 32'(v);
    e.wen = (op inside {7'h33, 7'h13, 7'h03, 7'h37, 7'h17, 7'h6F, 7'h67}) && (w[11:7] != 5'd0);
    return e;
  endfunction

  function automatic logic ref_hazard(input logic [31:0] w);
    logic u1, u2;
    u1 = !(w[6:0] inside {7'h37, 7'h17, 7'h6F});
    u2 = w[6:0] inside {7'h33, 7'h23, 7'h63};
    return ex_load_valid && ex_load_rd != 5'd0 &&
           ((u1 && ex_load_rd == w[19:15]) || (u2 && ex_load_rd == w[24:20]));
  endfunction

  function automatic logic [31:0] arch(input logic [4:0] r);
    return (r == 5'd0) ? 32'd0 : rf[r];
  endfunction

  // Monitor: handshake and consumed ID/EX contents checked mid-cycle.
  always @(negedge clk) begin
    logic er;
    exp_t e;
    if (!n_rst) begin
      mvalid = 1'b0;
      sbq.delete();
      acc_seen = 1'b0;
    end else begin
      er = !flush && !ref_hazard(if_instr) && (!mvalid || id_ready);
      chk("if_ready", 32'(if_ready), 32'(er));
      chk("id_valid", 32'(id_valid), 32'(mvalid));
      if (mvalid && id_ready && !flush) begin
        if (sbq.size() == 0) begin
          chk("sb_nonempty", 32'd0, 32'd1);
        end else begin
          e = sbq.pop_front();
          chk("id_pc", id_pc, e.pc);
          chk("id_rs1", 32'(id_rs1), 32'(e.rs1));
          chk("id_rs2", 32'(id_rs2), 32'(e.rs2));
          chk("id_rd", 32'(id_rd), 32'(e.rd));
          chk("id_opcode", 32'(id_opcode), 32'(e.opc));
          chk("id_funct3", 32'(id_funct3), 32'(e.f3));
          chk("id_funct7b5", 32'(id_funct7b5), 32'(e.f7));
          chk("id_imm", id_imm, e.imm);
          chk("id_rd_wen", 32'(id_rd_wen), 32'(e.wen));
          chk("id_illegal", 32'(id_illegal), 32'(e.ill));
          chk("id_rs1_val", id_rs1_val, arch(e.rs1));
          chk("id_rs2_val", id_rs2_val, arch(e.rs2));
        end
      end
      if (flush) begin
        mvalid = 1'b0;
        sbq.delete();
      end else if (if_valid && er) begin
        sbq.push_back(ref_decode(if_instr, if_pc));
        mvalid = 1'b1;
      end else if (id_ready) begin
        mvalid = 1'b0;
      end
      acc_seen = if_valid && if_ready;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (wb_wen) rf[wb_sel] = wb_data;
  endtask

  task automatic set_in(input logic v, input logic [31:0] w, input logic idr,
                        input logic fl, input logic wbw, input logic [4:0] wbs,
                        input logic [31:0] wbd, input logic exl, input logic [4:0] exr);
    if_valid = v; if_instr = w; if_pc = $urandom & 32'hFFFFFFFC; id_ready = idr; flush = fl;
    wb_wen = wbw; wb_sel = wbs; wb_data = wbd; ex_load_valid = exl; ex_load_rd = exr;
  endtask

  function automatic logic [31:0] gen_instr();
    logic [31:0] w;
    w = $urandom;
    w[6:0]   = ops[$urandom_range(0, 9)];
    w[11:7]  = 5'($urandom_range(0, 3));
    w[19:15] = 5'($urandom_range(0, 3));
    w[24:20] = 5'($urandom_range(0, 3));
    return w;
  endfunction

  localparam logic [31:0] ADDI = 32'hFFD00293;
  localparam logic [31:0] ADD  = 32'h002081B3;

  initial begin
    ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F};
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    set_in(0, 32'h0, 0, 0, 0, 5'd0, 32'h0, 0, 5'd0);
    n_rst = 1'b1;
    #1 n_rst = 1'b0;
    #1;
    chk("rst_id_valid", 32'(id_valid), 32'd0);
    chk("rst_id_imm", id_imm, 32'd0);
    chk("rst_id_rs1_val", id_rs1_val, 32'd0);
    chk("rst_id_rd_wen", 32'(id_rd_wen), 32'd0);
    @(posedge clk); #1 n_rst = 1'b1;

    set_in(1, ADDI, 1, 0, 0, 5'd0, 32'h0, 0, 5'd0);
    tick(); #1;
    chk("addi_valid", 32'(id_valid), 32'd1);
    chk("addi_imm", id_imm, 32'hFFFFFFFD);
    chk("addi_rd", 32'(id_rd), 32'd5);
    chk("addi_rd_wen", 32'(id_rd_wen), 32'd1);
    chk("addi_rs1_val", id_rs1_val, 32'd0);

    rf[1] = 32'h10; rf[2] = 32'h20;
    set_in(1, ADD, 1, 0, 1, 5'd2, 32'h99, 0, 5'd0);
    tick(); #1;
    chk("byp_rs1_val", id_rs1_val, 32'h10);
    chk("byp_rs2_val", id_rs2_val, 32'h99);

    set_in(1, ADD, 1, 0, 0, 5'd0, 32'h0, 1, 5'd1);
    #1 chk("lu_if_ready", 32'(if_ready), 32'd0);
    tick(); #1;
    chk("lu_bubble", 32'(id_valid), 32'd0);
    ex_load_valid = 1'b0;
    #1 chk("lu_release", 32'(if_ready), 32'd1);
    tick(); #1;
    chk("lu_capture", 32'(id_valid), 32'd1);

    set_in(1, ADDI, 0, 0, 1, 5'd1, 32'hABCD, 0, 5'd0);
    #1 chk("hold_if_ready", 32'(if_ready), 32'd0);
    tick(); #1;
    chk("hold_refresh", id_rs1_val, 32'hABCD);
    wb_wen = 1'b0;
    #1 chk("hold_if_ready2", 32'(if_ready), 32'd0);
    id_ready = 1'b1;
    #1 chk("hold_release", 32'(if_ready), 32'd1);
    tick();

    set_in(1, ADD, 0, 1, 0, 5'd0, 32'h0, 0, 5'd0);
    #1 chk("flush_if_ready", 32'(if_ready), 32'd0);
    tick(); #1;
    chk("flush_id_valid", 32'(id_valid), 32'd0);

    set_in(1, 32'hFE000CE3, 1, 0, 0, 5'd0, 32'h0, 0, 5'd0);
    tick(); #1;
    chk("beq_imm", id_imm, 32'hFFFFFFF8);
    chk("beq_rd_wen", 32'(id_rd_wen), 32'd0);

    set_in(1, 32'h0000007F, 1, 0, 0, 5'd0, 32'h0, 0, 5'd0);
    tick(); #1;
    chk("ill_flag", 32'(id_illegal), 32'd1);

    set_in(1, ADDI, 0, 0, 0, 5'd0, 32'h0, 0, 5'd0);
    tick(); #1;
    n_rst = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(id_valid), 32'd0);
    chk("mid_rst_pc", id_pc, 32'd0);
    chk("mid_rst_imm", id_imm, 32'd0);
    chk("mid_rst_illegal", 32'(id_illegal), 32'd0);
    tick();
    n_rst = 1'b1;

    for (int c = 0; c < 4000; c++) begin
      if (!(if_valid && !acc_seen && !flush)) begin
        if_valid = ($urandom_range(0, 3) != 0);
        if_instr = gen_instr();
        if_pc    = $urandom & 32'hFFFFFFFC;
      end
      id_ready      = ($urandom_range(0, 3) != 0);
      flush         = ($urandom_range(0, 15) == 0);
      wb_wen        = $urandom_range(0, 1) != 0;
      wb_sel        = 5'($urandom_range(0, 3));
      wb_data       = $urandom;
      ex_load_valid = ($urandom_range(0, 3) == 0);
      ex_load_rd    = 5'($urandom_range(0, 3));
      tick();
    end

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
